sdram_ctrl: RTL and testbench
=============================

SDRAM_CTRL -- requirements
Module: sdram_ctrl

Interface
REQ-001 Parameters SHALL be: INIT_CYCLES, 10000, power-up wait before first command; REFRESH_CYCLES, 780, clocks between auto-refreshes; T_RP, 2, precharge period; T_RCD, 2, activate-to-read/write; T_RFC, 7, refresh period; T_MRD, 2, mode-register set period; T_WR, 2, write recovery; CAS_LAT, 2, CAS latency (2 or 3).
REQ-002 Clock and reset SHALL be: clk in 1 (single clock for all logic); rst in 1 (synchronous, active-high).
REQ-003 Request ports SHALL be: req_valid in 1 (request present); req_ready out 1 (request accepted this cycle when both high); req_we in 1 (1 write, 0 read); req_addr in 21 (word address: bank [20:19], row [18:8], column [7:0]); req_wdata in 32 (write data); req_be in 2 (halfword enables: [1] bits 31:16, [0] bits 15:0).
REQ-004 Read-return ports SHALL be: rd_valid out 1 (one-cycle strobe); rd_data out 32 (read word).
REQ-005 Device-side ports SHALL be: sdr_cke out 1; sdr_ras_n, sdr_cas_n, sdr_we_n out 1 each; sdr_ba out 2; sdr_addr out 11; sdr_dm out 1 (masks dq[31:16]); sdr_dm0 out 1 (masks dq[15:0]); sdr_dq_o out 32; sdr_dq_oe out 1 (drive enable); sdr_dq_i in 32.

Function
REQ-006 All device-side outputs SHALL be registered; commands encoded {ras_n,cas_n,we_n}: NOP 111, ACTIVE 011, READ 101, WRITE 100, PRECHARGE 010, REFRESH 001, MRS 000.
REQ-007 Non-command cycles SHALL drive NOP, sdr_dq_oe=0, sdr_dm=sdr_dm0=1.
REQ-008 States SHALL be: PWRUP, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS, IDLE, ACT, RD, WR, REF, WAIT; WAIT counts a loaded delay down, then enters its stored next state.
REQ-009 PWRUP SHALL hold NOP with sdr_cke=1 for INIT_CYCLES clocks, then INIT_PRE.
REQ-010 INIT_PRE SHALL issue PRECHARGE with sdr_addr[10]=1 (all banks), wait T_RP; INIT_REF1 and INIT_REF2 SHALL each issue REFRESH, wait T_RFC.
REQ-011 INIT_MRS SHALL issue MRS with sdr_ba=0, sdr_addr=11'h020 (CAS_LAT=2) or 11'h030 (CAS_LAT=3): burst length 1, sequential; wait T_MRD, then IDLE.
REQ-012 req_ready SHALL be 1 only in IDLE with no refresh pending; a request is accepted on clk edge with req_valid&&req_ready, all req_* fields captured.
REQ-013 On acceptance, ACT SHALL issue ACTIVE (sdr_ba=addr[20:19], sdr_addr=addr[18:8]) next cycle, wait T_RCD, then RD or WR.
REQ-014 RD/WR SHALL issue READ/WRITE with sdr_addr={3'b100, column} (A10=1 auto-precharge) and the captured bank.
REQ-015 WR SHALL in the same cycle drive sdr_dq_o=wdata, sdr_dq_oe=1, sdr_dm=~be[1], sdr_dm0=~be[0]; then wait T_WR+T_RP before IDLE.
REQ-016 With READ on the pins during cycle T, sdr_dq_i SHALL be sampled at the end of cycle T+CAS_LAT, and rd_data valid with rd_valid=1 during cycle T+CAS_LAT+1 only; RD then waits until after that cycle and T_RP elapsed before IDLE.
REQ-017 A refresh interval counter SHALL count from REFRESH_CYCLES-1 to 0 from leaving INIT_MRS, reload and set refresh_pending at 0; it keeps counting during all activity.
REQ-018 In IDLE, refresh_pending SHALL take priority over req_valid: REF issues REFRESH, clears refresh_pending, waits T_RFC.
REQ-019 Expiry while pending SHALL leave refresh_pending set (not counted twice).
REQ-020 req_be=2'b00 writes SHALL still issue the full ACT/WRITE sequence with both masks high.
REQ-021 No new request SHALL be accepted before the previous one completes (one outstanding transaction).

Reset
REQ-022 rst SHALL force state PWRUP, restart the power-up count, clear refresh_pending, and set sdr_cke=0 for that cycle (1 thereafter), NOP, sdr_ba=0, sdr_addr=0, sdr_dq_o=0, sdr_dq_oe=0, sdr_dm=sdr_dm0=1, req_ready=0, rd_valid=0, rd_data=0.
REQ-023 Reset mid-transaction SHALL abandon it without rd_valid and rerun full initialisation.

Verification
REQ-024 Init: release rst with INIT_CYCLES=20 -> NOP x20, PRECHARGE A10=1, +2 REFRESH T_RFC apart, MRS 11'h020, req_ready=1 after T_MRD.
REQ-025 Write/read: write addr 21'h1F_0A55, data 32'hDEADBEEF, be=2'b11, then read it -> ACTIVE ba=3 row=11'h70A, WRITE/READ sdr_addr=11'h455, rd_data=32'hDEADBEEF 2+1 cycles after READ (CAS_LAT=2).
REQ-026 Masking: write be=2'b01 -> WRITE cycle sdr_dm=1, sdr_dm0=0, sdr_dq_oe=1 for exactly one cycle.
REQ-027 Refresh priority: raise req_valid the cycle refresh_pending sets -> REFRESH first, req_ready=0 for T_RFC, then request proceeds.
REQ-028 Reset mid-read: assert rst one cycle after READ -> no rd_valid, PWRUP restarts, sdr_cke=0 that cycle.

Source files
------------

// File: rtl/sdram_ctrl.sv
// sdram_ctrl: single-word SDRAM controller with power-up init,
// periodic auto-refresh and auto-precharge read/write accesses.
module sdram_ctrl #(
  parameter int INIT_CYCLES    = 10000,
  parameter int REFRESH_CYCLES = 780,
  parameter int T_RP           = 2,
  parameter int T_RCD          = 2,
  parameter int T_RFC          = 7,
  parameter int T_MRD          = 2,
  parameter int T_WR           = 2,
  parameter int CAS_LAT        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [20:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_be,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        sdr_cke,
  output logic        sdr_ras_n,
  output logic        sdr_cas_n,
  output logic        sdr_we_n,
  output logic [1:0]  sdr_ba,
  output logic [10:0] sdr_addr,
  output logic        sdr_dm,
  output logic        sdr_dm0,
  output logic [31:0] sdr_dq_o,
  output logic        sdr_dq_oe,
  input  logic [31:0] sdr_dq_i
);
  localparam int CW0 = $clog2(INIT_CYCLES + 1);
  localparam int CW  = (CW0 > 6) ? CW0 : 6;
  localparam int RW0 = $clog2(REFRESH_CYCLES);
  localparam int RW  = (RW0 > 1) ? RW0 : 1;
  localparam int RD_DLY = (CAS_LAT + 2 > T_RP) ? CAS_LAT + 2 : T_RP;
  localparam logic [10:0] MODE = (CAS_LAT == 3) ? 11'h030 : 11'h020;

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_MRS = 3'b000;

  typedef enum logic [3:0] {
    PWRUP, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS,
    IDLE, ACT, RD, WR, REF, WAIT
  } state_t;

  state_t        state, state_d, ret, ret_d, tgt;
  logic [CW-1:0] cnt, cnt_d, dly;
  logic          go;
  logic [RW-1:0] rcnt;
  logic          ref_en, ref_pend;
  logic          we_q;
  logic [1:0]    ba_q, be_q;
  logic [7:0]    col_q;
  logic [31:0]   wdata_q;
  logic [CAS_LAT-1:0] rd_sh;

  logic [2:0]  cmd_d;
  logic [1:0]  ba_d, dm_d;
  logic [10:0] a_d;
  logic [31:0] dq_d;
  logic        oe_d;

  assign req_ready = (state == IDLE) && !ref_pend;

  // Timed states either hop straight to tgt or park in WAIT for dly cycles.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ret_d   = ret;
    tgt     = state;
    dly     = '0;
    go      = 1'b0;
    unique case (state)
      PWRUP: begin
        if (cnt == '0) state_d = INIT_PRE;
        else cnt_d = cnt - CW'(1);
      end
      INIT_PRE: begin
        go = 1'b1; tgt = INIT_REF1; dly = CW'(T_RP);
      end
      INIT_REF1: begin
        go = 1'b1; tgt = INIT_REF2; dly = CW'(T_RFC);
      end
      INIT_REF2: begin
        go = 1'b1; tgt = INIT_MRS; dly = CW'(T_RFC);
      end
      INIT_MRS: begin
        go = 1'b1; tgt = IDLE; dly = CW'(T_MRD);
      end
      IDLE: begin
        if (ref_pend) state_d = REF;
        else if (req_valid) state_d = ACT;
      end
      ACT: begin
        go = 1'b1; tgt = we_q ? WR : RD; dly = CW'(T_RCD);
      end
      RD: begin
        go = 1'b1; tgt = IDLE; dly = CW'(RD_DLY);
      end
      WR: begin
        go = 1'b1; tgt = IDLE; dly = CW'(T_WR + T_RP);
      end
      REF: begin
        go = 1'b1; tgt = IDLE; dly = CW'(T_RFC);
      end
      WAIT: begin
        if (cnt == '0) state_d = ret;
        else cnt_d = cnt - CW'(1);
      end
      default: state_d = PWRUP;
    endcase
    if (go) begin
      if (dly <= CW'(1)) begin
        state_d = tgt;
      end else begin
        state_d = WAIT;
        cnt_d   = dly - CW'(2);
        ret_d   = tgt;
      end
    end
  end

  // Pins are decoded from the next state so they line up with state.
  always_comb begin
    cmd_d = CMD_NOP;
    ba_d  = '0;
    a_d   = '0;
    dq_d  = '0;
    oe_d  = 1'b0;
    dm_d  = 2'b11;
    case (state_d)
      INIT_PRE: begin
        cmd_d = CMD_PRE; a_d = 11'h400;
      end
      INIT_REF1, INIT_REF2, REF: cmd_d = CMD_REF;
      INIT_MRS: begin
        cmd_d = CMD_MRS; a_d = MODE;
      end
      ACT: begin
        cmd_d = CMD_ACT;
        ba_d  = req_addr[20:19];
        a_d   = req_addr[18:8];
      end
      RD: begin
        cmd_d = CMD_RD; ba_d = ba_q; a_d = {3'b100, col_q};
      end
      WR: begin
        cmd_d = CMD_WR; ba_d = ba_q; a_d = {3'b100, col_q};
        dq_d  = wdata_q; oe_d = 1'b1; dm_d = ~be_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PWRUP;
      cnt      <= CW'(INIT_CYCLES - 1);
      ret      <= IDLE;
      rcnt     <= '0;
      ref_en   <= 1'b0;
      ref_pend <= 1'b0;
      rd_sh    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      sdr_cke  <= 1'b0;
      {sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_NOP;
      sdr_ba    <= '0;
      sdr_addr  <= '0;
      sdr_dq_o  <= '0;
      sdr_dq_oe <= 1'b0;
      {sdr_dm, sdr_dm0} <= 2'b11;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      ret     <= ret_d;
      sdr_cke <= 1'b1;
      {sdr_ras_n, sdr_cas_n, sdr_we_n} <= cmd_d;
      sdr_ba    <= ba_d;
      sdr_addr  <= a_d;
      sdr_dq_o  <= dq_d;
      sdr_dq_oe <= oe_d;
      {sdr_dm, sdr_dm0} <= dm_d;
      rd_sh    <= {rd_sh[CAS_LAT-2:0], state == RD};
      rd_valid <= rd_sh[CAS_LAT-1];
      if (rd_sh[CAS_LAT-1]) rd_data <= sdr_dq_i;
      if (state == INIT_MRS) begin
        ref_en <= 1'b1;
        rcnt   <= RW'(REFRESH_CYCLES - 1);
      end else if (ref_en) begin
        if (rcnt == '0) rcnt <= RW'(REFRESH_CYCLES - 1);
        else rcnt <= rcnt - RW'(1);
      end
      if (ref_en && rcnt == '0) ref_pend <= 1'b1;
      else if (state_d == REF) ref_pend <= 1'b0;
      if (req_valid && req_ready) begin
        we_q    <= req_we;
        ba_q    <= req_addr[20:19];
        col_q   <= req_addr[7:0];
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end
endmodule

// File: tb/tb_sdram_ctrl.sv
// tb_sdram_ctrl: directed bench for sdram_ctrl with a tiny
// device model answering READs CAS_LAT cycles later.
module tb_sdram_ctrl;
  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_MRS = 3'b000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [20:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_be = '0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        sdr_cke, sdr_ras_n, sdr_cas_n, sdr_we_n;
  logic [1:0]  sdr_ba;
  logic [10:0] sdr_addr;
  logic        sdr_dm, sdr_dm0;
  logic [31:0] sdr_dq_o;
  logic        sdr_dq_oe;
  logic [31:0] sdr_dq_i = 32'h5A5A_5A5A;

  always #5 clk = ~clk;

  sdram_ctrl #(.INIT_CYCLES(20), .REFRESH_CYCLES(40)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .sdr_cke(sdr_cke), .sdr_ras_n(sdr_ras_n),
    .sdr_cas_n(sdr_cas_n), .sdr_we_n(sdr_we_n),
    .sdr_ba(sdr_ba), .sdr_addr(sdr_addr),
    .sdr_dm(sdr_dm), .sdr_dm0(sdr_dm0),
    .sdr_dq_o(sdr_dq_o), .sdr_dq_oe(sdr_dq_oe),
    .sdr_dq_i(sdr_dq_i)
  );

  wire [2:0] cmd = {sdr_ras_n, sdr_cas_n, sdr_we_n};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Device model: 64 words indexed by bank, low row and low column bits.
  logic [1:0]  open_row [4]  = '{default: 2'b00};
  logic [31:0] mem      [64] = '{default: 32'h0};
  logic        rd_pend = 1'b0;
  logic [31:0] rd_word = '0;

  function automatic logic [5:0] idx(input logic [1:0] b,
                                     input logic [1:0] r,
                                     input logic [1:0] c);
    return {b, r, c};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic m1, input logic m0);
    return {m1 ? o[31:16] : n[31:16], m0 ? o[15:0] : n[15:0]};
  endfunction

  always @(posedge clk) begin
    rd_pend <= 1'b0;
    if (cmd == C_ACT) open_row[sdr_ba] <= sdr_addr[1:0];
    if (cmd == C_WR)
      mem[idx(sdr_ba, open_row[sdr_ba], sdr_addr[1:0])] <=
        merge(mem[idx(sdr_ba, open_row[sdr_ba], sdr_addr[1:0])],
              sdr_dq_o, sdr_dm, sdr_dm0);
    if (cmd == C_RD) begin
      rd_pend <= 1'b1;
      rd_word <= mem[idx(sdr_ba, open_row[sdr_ba], sdr_addr[1:0])];
    end
    sdr_dq_i <= rd_pend ? rd_word : 32'h5A5A_5A5A;
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Presents a request and returns in the cycle after acceptance.
  task automatic issue(input logic we, input logic [20:0] a,
                       input logic [31:0] d, input logic [1:0] be,
                       output bit ok);
    req_we = we; req_addr = a; req_wdata = d; req_be = be;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (req_ready === 1'b1) ok = 1'b1;
      tick;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [61:0] got, exp;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    cyc = 0;
    got = {sdr_cke, cmd, sdr_ba, sdr_addr, sdr_dq_oe, sdr_dm, sdr_dm0,
           req_ready, rd_valid, rd_data, sdr_dq_o[4:0]};
    exp = {1'b0, C_NOP, 2'b00, 11'h000, 1'b0, 1'b1, 1'b1,
           1'b0, 1'b0, 32'h0, 5'h0};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_state got %h want %h", got, exp);
    end
  endtask

  task automatic test_init;
    logic [2:0] exp;
    for (int c = 0; c <= 38; c++) begin
      exp = (c == 20) ? C_PRE :
            (c == 22 || c == 29) ? C_REF :
            (c == 36) ? C_MRS : C_NOP;
      n_tests++;
      if (cmd !== exp) begin
        n_fail++;
        $display("FAIL init_cmd c=%0d got %b want %b", c, cmd, exp);
      end
      if (c == 1) begin
        n_tests++;
        if (sdr_cke !== 1'b1) begin
          n_fail++;
          $display("FAIL init_cke got %b want 1", sdr_cke);
        end
      end
      if (c == 20) begin
        n_tests++;
        if (sdr_addr[10] !== 1'b1) begin
          n_fail++;
          $display("FAIL init_pre_a10 got %b want 1", sdr_addr[10]);
        end
      end
      if (c == 36) begin
        n_tests++;
        if ({sdr_ba, sdr_addr} !== {2'b00, 11'h020}) begin
          n_fail++;
          $display("FAIL init_mrs got ba=%0d a=%h want 0/020",
                   sdr_ba, sdr_addr);
        end
      end
      if (c == 37 || c == 38) begin
        n_tests++;
        if (req_ready !== (c == 38)) begin
          n_fail++;
          $display("FAIL init_ready c=%0d got %b", c, req_ready);
        end
      end
      if (c < 38) tick;
    end
  endtask

  task automatic test_refresh_priority;
    int bad = 0;
    while (cyc < 77) tick;
    req_we = 1'b1; req_addr = 21'h0_1234;
    req_wdata = 32'h0123_4567; req_be = 2'b11;
    req_valid = 1'b1;
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ref_pend_ready got %b want 0", req_ready);
    end
    tick;
    n_tests++;
    if (cmd !== C_REF) begin
      n_fail++;
      $display("FAIL ref_cmd got %b want %b", cmd, C_REF);
    end
    for (int i = 0; i < 7; i++) begin
      if (req_ready !== 1'b0) bad++;
      tick;
    end
    n_tests++;
    if (bad != 0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ref_ready_gap bad=%0d ready=%b want 0/1",
               bad, req_ready);
    end
    tick;
    req_valid = 1'b0;
    n_tests++;
    if ({cmd, sdr_ba, sdr_addr} !== {C_ACT, 2'd0, 11'h012}) begin
      n_fail++;
      $display("FAIL ref_then_act got %b/%0d/%h", cmd, sdr_ba, sdr_addr);
    end
    tick;
    tick;
    n_tests++;
    if ({cmd, sdr_addr} !== {C_WR, 11'h434}) begin
      n_fail++;
      $display("FAIL ref_then_wr got %b/%h", cmd, sdr_addr);
    end
  endtask

  task automatic test_write_read;
    bit ok;
    issue(1'b1, 21'h1F_0A55, 32'hDEAD_BEEF, 2'b11, ok);
    n_tests++;
    if (!ok || {cmd, sdr_ba, sdr_addr} !== {C_ACT, 2'd3, 11'h70A}) begin
      n_fail++;
      $display("FAIL wr_act ok=%0d got %b/%0d/%h", ok, cmd, sdr_ba, sdr_addr);
    end
    tick;
    tick;
    n_tests++;
    if ({cmd, sdr_ba, sdr_addr, sdr_dq_oe, sdr_dm, sdr_dm0, sdr_dq_o} !==
        {C_WR, 2'd3, 11'h455, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL wr_cmd got %b/%0d/%h oe=%b dm=%b%b dq=%h",
               cmd, sdr_ba, sdr_addr, sdr_dq_oe, sdr_dm, sdr_dm0, sdr_dq_o);
    end
    issue(1'b0, 21'h1F_0A55, 32'h0, 2'b11, ok);
    n_tests++;
    if (!ok || {cmd, sdr_ba, sdr_addr} !== {C_ACT, 2'd3, 11'h70A}) begin
      n_fail++;
      $display("FAIL rd_act ok=%0d got %b/%0d/%h", ok, cmd, sdr_ba, sdr_addr);
    end
    tick;
    tick;
    n_tests++;
    if ({cmd, sdr_ba, sdr_addr, sdr_dq_oe} !==
        {C_RD, 2'd3, 11'h455, 1'b0}) begin
      n_fail++;
      $display("FAIL rd_cmd got %b/%0d/%h oe=%b",
               cmd, sdr_ba, sdr_addr, sdr_dq_oe);
    end
    tick;
    tick;
    n_tests++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_early got %b want 0", rd_valid);
    end
    tick;
    n_tests++;
    if ({rd_valid, rd_data} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL rd_data got %b/%h want 1/deadbeef", rd_valid, rd_data);
    end
    tick;
    n_tests++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_strobe_len got %b want 0", rd_valid);
    end
  endtask

  task automatic test_mask;
    bit ok;
    int n_oe = 0;
    issue(1'b1, 21'h1F_0A55, 32'hCAFE_1234, 2'b01, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mask_accept got 0 want 1");
    end
    for (int i = 0; i < 8; i++) begin
      if (sdr_dq_oe === 1'b1) n_oe++;
      if (i == 2) begin
        n_tests++;
        if ({cmd, sdr_dm, sdr_dm0, sdr_dq_oe, sdr_dq_o} !==
            {C_WR, 1'b1, 1'b0, 1'b1, 32'hCAFE_1234}) begin
          n_fail++;
          $display("FAIL mask_wr got %b dm=%b%b oe=%b dq=%h",
                   cmd, sdr_dm, sdr_dm0, sdr_dq_oe, sdr_dq_o);
        end
      end
      tick;
    end
    n_tests++;
    if (n_oe != 1) begin
      n_fail++;
      $display("FAIL mask_oe_len got %0d want 1", n_oe);
    end
  endtask

  task automatic test_be_zero;
    bit ok;
    issue(1'b1, 21'h1F_0A55, 32'h1111_2222, 2'b00, ok);
    n_tests++;
    if (!ok || cmd !== C_ACT) begin
      n_fail++;
      $display("FAIL be0_act ok=%0d got %b", ok, cmd);
    end
    tick;
    tick;
    n_tests++;
    if ({cmd, sdr_dm, sdr_dm0, sdr_dq_oe} !== {C_WR, 1'b1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL be0_wr got %b dm=%b%b oe=%b",
               cmd, sdr_dm, sdr_dm0, sdr_dq_oe);
    end
    issue(1'b0, 21'h1F_0A55, 32'h0, 2'b11, ok);
    for (int i = 0; i < 5; i++) tick;
    n_tests++;
    if (!ok || {rd_valid, rd_data} !== {1'b1, 32'hDEAD_1234}) begin
      n_fail++;
      $display("FAIL be0_readback ok=%0d got %b/%h want 1/dead1234",
               ok, rd_valid, rd_data);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int bad = 0;
    int gap = 0;
    bit found = 1'b0;
    issue(1'b1, 21'h0_0F00, 32'hAAAA_5555, 2'b11, ok);
    req_we = 1'b0; req_addr = 21'h0_0F00; req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (req_ready !== 1'b0 || (i > 0 && cmd === C_ACT)) bad++;
      tick;
    end
    n_tests++;
    if (!ok || bad != 0) begin
      n_fail++;
      $display("FAIL b2b_hold ok=%0d bad=%0d want 1/0", ok, bad);
    end
    gap = 6;
    for (int i = 0; i < 40 && !found; i++) begin
      tick;
      gap++;
      if (cmd === C_ACT) found = 1'b1;
    end
    req_valid = 1'b0;
    n_tests++;
    if (!found || gap < 7) begin
      n_fail++;
      $display("FAIL b2b_second found=%0d gap=%0d want 1/>=7", found, gap);
    end
    for (int i = 0; i < 5; i++) tick;
    n_tests++;
    if ({rd_valid, rd_data} !== {1'b1, 32'hAAAA_5555}) begin
      n_fail++;
      $display("FAIL b2b_rdata got %b/%h want 1/aaaa5555", rd_valid, rd_data);
    end
  endtask

  task automatic test_reset_mid_read;
    bit ok;
    int n_rv = 0;
    issue(1'b0, 21'h1F_0A55, 32'h0, 2'b11, ok);
    tick;
    tick;
    n_tests++;
    if (!ok || cmd !== C_RD) begin
      n_fail++;
      $display("FAIL rst_rd_cmd ok=%0d got %b", ok, cmd);
    end
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_tests++;
    if ({sdr_cke, cmd, req_ready, rd_valid} !== {1'b0, C_NOP, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_state got cke=%b cmd=%b rdy=%b rv=%b",
               sdr_cke, cmd, req_ready, rd_valid);
    end
    for (int c = 0; c < 25; c++) begin
      if (rd_valid === 1'b1) n_rv++;
      if (c == 20) begin
        n_tests++;
        if ({cmd, sdr_addr[10]} !== {C_PRE, 1'b1}) begin
          n_fail++;
          $display("FAIL rst_reinit_pre got %b a10=%b", cmd, sdr_addr[10]);
        end
      end
      tick;
    end
    n_tests++;
    if (n_rv != 0) begin
      n_fail++;
      $display("FAIL rst_no_rdvalid got %0d want 0", n_rv);
    end
  endtask

  initial begin
    test_reset;
    test_init;
    test_refresh_priority;
    test_write_read;
    test_mask;
    test_be_zero;
    test_back_to_back;
    test_reset_mid_read;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
